// File: rtl/mem_window_display.sv
// Memory window browser for the touchscreen LCD.
// Periodically sweeps WORDS words from a base address into a display buffer.
module mem_window_display #(
   parameter int WORDS    = 8,
   parameter int READ_LAT = 1,
   parameter int REFRESH  = 1000000
) (
   input  logic        clk,
   input  logic        resetn,
   input  logic        input_valid,
   input  logic [31:0] input_value,
   input  logic [5:0]  display_number,
   output logic        display_valid,
   output logic [39:0] display_name,
   output logic [31:0] display_value,
   output logic        mem_en,
   output logic [29:0] mem_addr,
   input  logic [31:0] mem_rdata
);

   localparam int IW = (WORDS > 1) ? $clog2(WORDS) : 1;
   localparam logic [31:0] PAGE = 32'(4 * WORDS);

   typedef enum logic [1:0] {IDLE, ISSUE, WAIT, HOLD} state_t;

   state_t        state;
   logic [31:0]   base;
   logic [31:0]   base_nxt;
   logic [31:0]   wbuf [WORDS];
   logic [IW-1:0] idx;
   logic [1:0]    lat_cnt;
   logic [31:0]   hold_cnt;
   logic          freeze;
   logic          pending;
   logic [15:0]   sweep_cnt;
   logic          cmd_base;
   logic          cmd_frz;
   logic [1:0]    op;
   logic          scanning;

   assign op       = input_value[1:0];
   assign cmd_base = input_valid && (op != 2'b11);
   assign cmd_frz  = input_valid && (op == 2'b11);
   assign scanning = (state == ISSUE) || (state == WAIT);

   always_comb begin
      base_nxt = base;
      if (input_valid) begin
         unique case (op)
            2'b00:   base_nxt = {input_value[31:2], 2'b00};
            2'b01:   base_nxt = base + PAGE;
            2'b10:   base_nxt = base - PAGE;
            default: base_nxt = base;
         endcase
      end
   end

   always_ff @(posedge clk) begin
      if (!resetn) begin
         state     <= IDLE;
         base      <= '0;
         idx       <= '0;
         lat_cnt   <= '0;
         hold_cnt  <= '0;
         freeze    <= 1'b0;
         pending   <= 1'b0;
         sweep_cnt <= '0;
         mem_en    <= 1'b0;
         mem_addr  <= '0;
         for (int i = 0; i < WORDS; i++) wbuf[i] <= '0;
      end else begin
         base   <= base_nxt;
         mem_en <= 1'b0;
         if (cmd_frz) freeze <= ~freeze;
         if (cmd_base) pending <= 1'b1;
         unique case (state)
            IDLE: begin
               state    <= ISSUE;
               idx      <= '0;
               mem_en   <= 1'b1;
               mem_addr <= base_nxt[31:2];
            end
            ISSUE: begin
               if (cmd_base) begin
                  idx      <= '0;
                  mem_en   <= 1'b1;
                  mem_addr <= base_nxt[31:2];
               end else begin
                  lat_cnt <= 2'(READ_LAT);
                  state   <= WAIT;
               end
            end
            WAIT: begin
               // a new base drops the in-flight read and restarts the window
               if (cmd_base) begin
                  state    <= ISSUE;
                  idx      <= '0;
                  mem_en   <= 1'b1;
                  mem_addr <= base_nxt[31:2];
               end else if (lat_cnt == 2'd1) begin
                  lat_cnt   <= 2'd0;
                  wbuf[idx] <= mem_rdata;
                  if (idx == IW'(WORDS - 1)) begin
                     sweep_cnt <= sweep_cnt + 16'd1;
                     pending   <= 1'b0;
                     hold_cnt  <= 32'(REFRESH);
                     state     <= HOLD;
                  end else begin
                     idx      <= idx + 1'b1;
                     state    <= ISSUE;
                     mem_en   <= 1'b1;
                     mem_addr <= base_nxt[31:2] + 30'(idx + 1'b1);
                  end
               end else begin
                  lat_cnt <= lat_cnt - 2'd1;
               end
            end
            HOLD: begin
               if (pending || (!freeze && hold_cnt == '0)) begin
                  state    <= ISSUE;
                  idx      <= '0;
                  mem_en   <= 1'b1;
                  mem_addr <= base_nxt[31:2];
               end else if (!freeze) begin
                  hold_cnt <= hold_cnt - 32'd1;
               end
            end
         endcase
      end
   end

   logic [5:0]  k;
   logic [5:0]  tens;
   logic [5:0]  ones;
   logic        dv;
   logic [39:0] dn;
   logic [31:0] dval;

   always_comb begin
      k    = display_number - 6'd3;
      tens = k / 6'd10;
      ones = k - tens * 6'd10;
      dv   = 1'b0;
      dn   = '0;
      dval = '0;
      unique case (1'b1)
         (display_number == 6'd1): begin
            dv   = 1'b1;
            dn   = 40'h4241534520;
            dval = base;
         end
         (display_number == 6'd2): begin
            dv   = 1'b1;
            dn   = 40'h5354415420;
            dval = {freeze, scanning, 14'b0, sweep_cnt};
         end
         (display_number >= 6'd3 && display_number <= 6'(WORDS + 2)): begin
            dv   = 1'b1;
            dn   = {8'h57, 8'h30 + {2'b00, tens},
                    8'h30 + {2'b00, ones}, 16'h2020};
            dval = wbuf[k[IW-1:0]];
         end
         default: ;
      endcase
   end

   always_ff @(posedge clk) begin
      if (!resetn) begin
         display_valid <= 1'b0;
         display_name  <= '0;
         display_value <= '0;
      end else begin
         display_valid <= dv;
         display_name  <= dn;
         display_value <= dval;
      end
   end

endmodule

// File: tb/tb_mem_window_display.sv
// Scoreboard bench for mem_window_display: expected read addresses and
// display contents come from a word-level model of the window.
module tb_mem_window_display;

   localparam int WORDS   = 4;
   localparam int RL      = 3;
   localparam int REFRESH = 40;
   localparam int PERIOD  = WORDS * (RL + 1) + REFRESH + 1;

   logic        clk = 1'b0;
   logic        resetn = 1'b0;
   logic        input_valid = 1'b0;
   logic [31:0] input_value = '0;
   logic [5:0]  display_number = '0;
   logic        display_valid;
   logic [39:0] display_name;
   logic [31:0] display_value;
   logic        mem_en;
   logic [29:0] mem_addr;
   logic [31:0] mem_rdata;

   always #5 clk = ~clk;

   mem_window_display #(
      .WORDS(WORDS), .READ_LAT(RL), .REFRESH(REFRESH)
   ) dut (
      .clk(clk), .resetn(resetn),
      .input_valid(input_valid), .input_value(input_value),
      .display_number(display_number), .display_valid(display_valid),
      .display_name(display_name), .display_value(display_value),
      .mem_en(mem_en), .mem_addr(mem_addr), .mem_rdata(mem_rdata)
   );

   int cyc = 0;
   always @(posedge clk) cyc <= cyc + 1;

   function automatic logic [31:0] memf(logic [29:0] a);
      return {2'b00, a} * 32'd3;
   endfunction

   // memory with RL cycles of latency; junk when no read is due
   logic [30:0] pipe [RL];
   always @(posedge clk) begin
      pipe[0] <= {mem_en, mem_addr};
      for (int i = 1; i < RL; i++) pipe[i] <= pipe[i-1];
   end
   always_comb begin
      mem_rdata = {16'hA5A5, 16'(cyc)};
      if (pipe[RL-1][30] === 1'b1) mem_rdata = memf(pipe[RL-1][29:0]);
   end

   typedef struct {
      int          due;
      string       nm;
      logic [79:0] act;
      logic [79:0] exp;
   } rec_t;

   rec_t        dq[$];
   rec_t        cq[$];
   logic [29:0] aq[$];
   int          en_times[$];
   int          en_count = 0;
   int          checks = 0;
   int          errors = 0;
   logic        rst_d = 1'b0;
   rec_t        mon_r;
   logic [29:0] mon_e;
   logic [79:0] mon_a;

   always @(posedge clk) rst_d <= resetn;

   always @(negedge clk) begin
      if (mem_en === 1'b1) begin
         en_times.push_back(cyc);
         en_count++;
         checks++;
         if (!rst_d) begin
            errors++;
            $display("FAIL mem_en_in_reset addr=%h", mem_addr);
         end else if (aq.size() == 0) begin
            errors++;
            $display("FAIL unexpected_mem_en got addr=%h want no read", mem_addr);
         end else begin
            mon_e = aq.pop_front();
            if (mem_addr !== mon_e) begin
               errors++;
               $display("FAIL mem_addr got %h want %h", mem_addr, mon_e);
            end
         end
      end
      while (dq.size() > 0 && dq[0].due <= cyc) begin
         mon_r = dq.pop_front();
         mon_a = 80'({display_valid, display_name, display_value});
         checks++;
         if (mon_r.due != cyc || mon_a !== mon_r.exp) begin
            errors++;
            $display("FAIL %s got %h want %h", mon_r.nm, mon_a, mon_r.exp);
         end
      end
      while (cq.size() > 0 && cq[0].due <= cyc) begin
         mon_r = cq.pop_front();
         checks++;
         if (mon_r.act !== mon_r.exp) begin
            errors++;
            $display("FAIL %s got %0h want %0h", mon_r.nm, mon_r.act, mon_r.exp);
         end
      end
   end

   logic [31:0] mbase = '0;
   logic        mfreeze = 1'b0;
   logic [15:0] msweep = '0;
   logic [31:0] mbuf [WORDS] = '{default: '0};

   task automatic check(string nm, logic [79:0] act, logic [79:0] exp);
      rec_t r;
      r.due = cyc;
      r.nm  = nm;
      r.act = act;
      r.exp = exp;
      cq.push_back(r);
   endtask

   function automatic logic [72:0] exp_slot(int n, logic scan);
      logic [39:0] nm;
      int          k;
      if (n == 1) return {1'b1, 40'h4241534520, mbase};
      if (n == 2) return {1'b1, 40'h5354415420, mfreeze, scan, 14'b0, msweep};
      if (n >= 3 && n <= WORDS + 2) begin
         k  = n - 3;
         nm = {8'h57, 8'(48 + k / 10), 8'(48 + k % 10), 16'h2020};
         return {1'b1, nm, mbuf[k]};
      end
      return '0;
   endfunction

   task automatic read_slot(int n, logic scan);
      rec_t r;
      @(negedge clk);
      display_number = 6'(n);
      r.due = cyc + 1;
      r.nm  = $sformatf("slot%0d", n);
      r.act = '0;
      r.exp = 80'(exp_slot(n, scan));
      dq.push_back(r);
   endtask

   task automatic read_all();
      read_slot(1, 1'b0);
      for (int n = 3; n <= WORDS + 2; n++) read_slot(n, 1'b0);
   endtask

   function automatic void apply(logic [31:0] v);
      case (v[1:0])
         2'b00: mbase = {v[31:2], 2'b00};
         2'b01: mbase = mbase + 32'(4 * WORDS);
         2'b10: mbase = mbase - 32'(4 * WORDS);
         default: mfreeze = ~mfreeze;
      endcase
   endfunction

   task automatic push_sweep(int n);
      for (int i = 0; i < n; i++) aq.push_back(mbase[31:2] + 30'(i));
   endtask

   function automatic void complete_sweep();
      for (int i = 0; i < WORDS; i++) mbuf[i] = memf(mbase[31:2] + 30'(i));
      msweep = msweep + 16'd1;
   endfunction

   task automatic cmd(logic [31:0] v, output int sc);
      @(negedge clk);
      input_valid = 1'b1;
      input_value = v;
      sc = cyc;
      @(negedge clk);
      input_valid = 1'b0;
   endtask

   task automatic wait_sweep();
      int n = 0;
      while (aq.size() != 0 && n < 500) begin
         @(negedge clk);
         n++;
      end
      check("sweep_done", 80'(aq.size()), 80'(0));
      aq.delete();
      repeat (RL + 2) @(negedge clk);
   endtask

   task automatic wait_en(int target);
      int n = 0;
      while (en_count < target && n < 1000) begin
         @(negedge clk);
         n++;
      end
      check("en_wait", 80'(en_count >= target), 80'(1));
   endtask

   task automatic sweep_cmd(logic [31:0] v);
      int sc;
      apply(v);
      push_sweep(WORDS);
      cmd(v, sc);
      wait_sweep();
      complete_sweep();
   endtask

   initial begin
      int          sc;
      int          e0;
      int          t0;
      int          lat;
      logic [31:0] v;

      repeat (4) @(negedge clk);
      display_number = 6'd1;
      repeat (2) @(negedge clk);
      check("rst_disp", 80'({display_valid, display_name, display_value}), 80'(0));
      check("rst_mem", 80'({mem_en, mem_addr}), 80'(0));

      push_sweep(WORDS);
      resetn = 1'b1;
      t0 = cyc;
      wait_sweep();
      complete_sweep();
      check("first_issue", 80'(en_times[0]), 80'(t0 + 1));
      check("issue_spacing", 80'(en_times[WORDS-1] - en_times[0]),
            80'((WORDS - 1) * (RL + 1)));
      read_all();
      read_slot(2, 1'b0);

      push_sweep(WORDS);
      wait_en(WORDS + 1);
      check("period", 80'(en_times[WORDS] - en_times[0]), 80'(PERIOD));
      apply(32'h3);
      cmd(32'h3, sc);
      wait_sweep();
      complete_sweep();
      repeat (3 * REFRESH) @(negedge clk);
      check("frozen_idle", 80'(en_count), 80'(2 * WORDS));
      read_slot(2, 1'b0);

      e0 = en_count;
      apply(32'h100);
      push_sweep(WORDS);
      cmd(32'h100, sc);
      wait_sweep();
      complete_sweep();
      lat = en_times[e0] - (sc + 1);
      check("cmd_latency", 80'(lat >= 1 && lat <= 2), 80'(1));
      read_all();
      repeat (3 * REFRESH) @(negedge clk);
      check("one_sweep_frozen", 80'(en_count), 80'(e0 + WORDS));

      v = $urandom();
      v[1:0] = 2'b01;
      sweep_cmd(v);
      read_slot(1, 1'b0);
      read_slot(3, 1'b0);

      for (int t = 0; t < 6; t++) begin
         v = $urandom();
         v[1:0] = 2'($urandom_range(0, 2));
         sweep_cmd(v);
         read_all();
      end

      sweep_cmd(32'hFFFF_FFF8);
      read_all();
      sweep_cmd(32'h0);
      sweep_cmd(32'h2);
      read_all();
      read_slot(2, 1'b0);

      e0 = en_count;
      apply(32'h1000);
      push_sweep(3);
      cmd(32'h1000, sc);
      wait_en(e0 + 3);
      apply(32'h200);
      push_sweep(WORDS);
      cmd(32'h200, sc);
      @(negedge clk);
      read_slot(5, 1'b0);
      read_slot(2, 1'b1);
      wait_sweep();
      complete_sweep();
      check("abort_restart", 80'(en_times[e0+3]), 80'(sc + 1));
      read_all();

      read_slot(WORDS + 3, 1'b0);
      read_slot(44, 1'b0);

      e0 = en_count;
      apply(32'h5000);
      push_sweep(WORDS);
      cmd(32'h5000, sc);
      wait_en(e0 + 2);
      @(negedge clk);
      display_number = 6'd3;
      resetn = 1'b0;
      repeat (2) @(negedge clk);
      aq.delete();
      mbase   = '0;
      mfreeze = 1'b0;
      msweep  = '0;
      for (int i = 0; i < WORDS; i++) mbuf[i] = '0;
      check("rst_mid_disp", 80'({display_valid, display_name, display_value}), 80'(0));
      check("rst_mid_mem", 80'({mem_en, mem_addr}), 80'(0));
      push_sweep(WORDS);
      resetn = 1'b1;
      wait_sweep();
      complete_sweep();
      read_all();
      read_slot(2, 1'b0);

      repeat (3) @(negedge clk);
      check("addr_queue_empty", 80'(aq.size()), 80'(0));
      repeat (3) @(negedge clk);
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL watchdog timeout at cycle %0d", cyc);
      $fatal(1, "timeout");
   end

endmodule

// File: doc/mem_window_display.md
# mem_window_display

Parametrised memory browser for the FPGA board's touchscreen LCD: shows a window of WORDS consecutive 32-bit words from a synchronous-read memory, starting at a user-set base address. It sits between the `lcd_module` display/input interface and a word-addressed memory read port such as an instruction ROM or data RAM. A scan state machine refreshes the window periodically. Touchscreen input supports set-base, page-up, page-down and freeze commands.

## Interface
- WORDS, 8: number of memory words displayed; legal range 1..40.
- READ_LAT, 1: memory read latency in cycles from `mem_en` to valid `mem_rdata`; legal range 1..3.
- REFRESH, 1000000: idle cycles between sweeps (100 ms at 10 MHz); legal range ≥1.
- clk  in  1  system clock, 10 MHz.
- resetn  in  1  reset, synchronous, active-low.
- input_valid  in  1  one-cycle pulse from `lcd_module`; a touchscreen value is present.
- input_value  in  32  command word: [31:2] address field, [1:0] opcode.
- display_number  in  6  display slot currently requested by `lcd_module`, 1..44.
- display_valid  out  1  the requested slot is in use.
- display_name  out  40  5-character ASCII label.
- display_value  out  32  value for the slot.
- mem_en  out  1  read strobe, one cycle per word.
- mem_addr  out  30  word address (byte address [31:2]).
- mem_rdata  in  32  read data, valid READ_LAT cycles after `mem_en`.

## Operation
- **Registers**
  - base[31:0]: bits [1:0] are always 0.
  - buf[0..WORDS-1]: 32 bits each.
  - idx: word index for the current sweep.
  - lat_cnt: read-latency counter.
  - hold_cnt: refresh counter.
  - freeze: 1 bit.
  - sweep_cnt: 16 bits, wraps.
  - pending: 1 bit.
- **Commands** (act only on an `input_valid` cycle)
  - 00: base ← {value[31:2], 2'b00}.
  - 01: page down, base ← base + 4·WORDS.
  - 10: page up, base ← base − 4·WORDS.
  - 11: toggle freeze; the address field is ignored.
  - Base arithmetic is modulo 2^32.
  - Opcodes 00, 01 and 10 set pending.
- **Word address** for index i is (base + 4·i) mod 2^32, so a window wraps past 0xFFFFFFFC to 0x00000000.
- **State machine**
  - IDLE: go to ISSUE with idx=0.
  - ISSUE: drive mem_en=1 and mem_addr=(base+4·idx)[31:2]; load lat_cnt=READ_LAT; go to WAIT.
  - WAIT: decrement lat_cnt. When it reaches 0, capture mem_rdata into buf[idx].
    - If idx=WORDS−1: increment sweep_cnt, clear pending, load hold_cnt=REFRESH, go to HOLD.
    - Otherwise: idx++ and go to ISSUE.
  - HOLD:
    - If pending=1: go to ISSUE with idx=0.
    - Else if freeze=0: decrement hold_cnt; when it reaches 0, go to ISSUE with idx=0.
    - Else (freeze=1, pending=0): stay in HOLD.
- **Abort on a base-changing command during ISSUE or WAIT**
  - Discard the in-flight read; it is not captured.
  - Restart at ISSUE with idx=0 on the next cycle, using the new base.
  - buf entries keep their old values until they are overwritten.
- **Freeze**
  - Toggling freeze never aborts an in-progress sweep.
  - A base-changing command issued while frozen runs exactly one sweep, then holds.
- **Display map**
  - Slot 1: "BASE ", value = base.
  - Slot 2: "STAT ", value = {freeze, scanning, 14'b0, sweep_cnt}. scanning=1 in ISSUE or WAIT.
  - Slots 3..WORDS+2: label "W" + two-digit decimal of (slot−3) + two spaces, e.g. "W00  ". Value = buf[slot−3].
  - All other slots: display_valid=0, name=0, value=0.

## Timing
- **Reset values**
  - Outputs: display_valid=0, display_name=0, display_value=0, mem_en=0, mem_addr=0.
  - State: base=0, buf all 0, freeze=0, sweep_cnt=0, pending=0, state=IDLE.
  - The first ISSUE occurs in the 2nd cycle after resetn rises.
- **Display outputs** are registered, one cycle after display_number.
- **Read cycle:** mem_en is high for exactly one cycle per word. buf[idx] is written on the clock edge READ_LAT cycles after the mem_en cycle. Each word takes READ_LAT+1 cycles.
- **Full sweep** takes WORDS·(READ_LAT+1) cycles. Sweep-to-sweep period is WORDS·(READ_LAT+1)+REFRESH+1 cycles.
- **Command effect:** base updates on the edge that samples input_valid. The next mem_en uses the new base no later than 2 cycles after that edge.
- **Reset mid-sweep:** everything returns to reset values on the next edge. No mem_en is issued while resetn=0.

## Test plan
- **Reset sweep:** reset, WORDS=4, READ_LAT=1, memory where mem[a]=a·3. Release reset → mem_addr steps 0,1,2,3 on mem_en cycles 2 apart. Slots 3..6 read 0,3,6,9. STAT sweep_cnt=1.
- **Set base:** input 0x00000100 with opcode 00 → slot 1 = 0x100. Next sweep mem_addr = 0x40..0x43. Slot 3 "W00  " = 0xC0.
- **Wrap and page:** base=0xFFFFFFF8, WORDS=4 → mem_addr sequence 0x3FFFFFFE, 0x3FFFFFFF, 0x0, 0x1. Opcode 10 at base=0 → base=0xFFFFFFF0.
- **Abort mid-sweep:** with READ_LAT=3, issue opcode 00 to base 0x200 while idx=2 in WAIT → no capture into buf[2] from the old read. Next mem_en has addr 0x80 with idx=0.
- **Freeze:** opcode 11 mid-sweep → the sweep completes, STAT[31]=1, and no mem_en for 3·REFRESH cycles. Opcode 01 while frozen → exactly one sweep at base+4·WORDS, then hold.
- **Unused slots:** display_number=WORDS+3 and display_number=44 → display_valid=0, name=0, value=0 one cycle later.
